// File: rtl/mcc_pkg.sv
// Shared types and the band classification helper for the multi-channel run counter.
package mcc_pkg;

  typedef enum logic [1:0] {
    BAND_LOW  = 2'b00,
    BAND_MID  = 2'b01,
    BAND_HIGH = 2'b10
  } band_t;

  // Thresholds are inclusive on the MID side: LO_TH <= cnt <= HI_TH.
  function automatic band_t classify(input logic [31:0] cnt,
                                     input int unsigned lo_th,
                                     input int unsigned hi_th);
    band_t b;
    if (cnt < lo_th) begin
      b = BAND_LOW;
    end else if (cnt <= hi_th) begin
      b = BAND_MID;
    end else begin
      b = BAND_HIGH;
    end
    return b;
  endfunction

endpackage

// File: rtl/mcc_channel.sv
// One channel: run counter with wrap/saturate, sticky sat flag, band FSM and band-dependent result.
module mcc_channel
  import mcc_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned LO_TH  = 4,
  parameter int unsigned HI_TH  = 16,
  parameter logic        CNT_ON = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic         clr,
  input  logic         en,
  input  logic         mode_sat,
  output logic [W-1:0] out,
  output band_t        band,
  output logic         evt,
  output logic         sat
);

  localparam int unsigned W2      = 2 * W;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_next;
  logic          sat_next;
  band_t         band_next;
  logic [W-1:0]  out_next;
  logic          evt_next;
  logic [W2-1:0] sq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sat  <= 1'b0;
      band <= BAND_LOW;
      out  <= '0;
      evt  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      sat  <= sat_next;
      band <= band_next;
      out  <= out_next;
      evt  <= evt_next;
    end
  end

  // Classification works on the registered count, so results trail cnt by one edge.
  always_comb begin
    cnt_next  = cnt;
    sat_next  = sat;
    band_next = classify(32'(cnt), LO_TH, HI_TH);
    out_next  = '0;
    evt_next  = 1'b0;
    sq        = W2'(cnt) * W2'(cnt);

    case (band_next)
      BAND_MID:  out_next = W'(sq);
      BAND_HIGH: out_next = cnt >> 1;
      default:   out_next = '0;
    endcase
    evt_next = (band_next != band);

    if (clr) begin
      cnt_next  = '0;
      sat_next  = 1'b0;
      band_next = BAND_LOW;
      out_next  = '0;
      evt_next  = 1'b0;
    end else if (en && (in == CNT_ON)) begin
      if (cnt != CNT_MAX) begin
        cnt_next = cnt + W'(1);
      end else if (mode_sat) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = '0;
      end
    end
  end

endmodule

// File: rtl/multi_cnt_classifier.sv
// Multi-channel run counter and classifier: CH independent mcc_channel instances plus port slicing.
module multi_cnt_classifier
  import mcc_pkg::*;
#(
  parameter int unsigned CH     = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned LO_TH  = 4,
  parameter int unsigned HI_TH  = 16,
  parameter logic        CNT_ON = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   in,
  input  logic [CH-1:0]   clr,
  input  logic            en,
  input  logic            mode_sat,
  output logic [CH*W-1:0] out,
  output logic [2*CH-1:0] band,
  output logic [CH-1:0]   evt,
  output logic [CH-1:0]   sat
);

  band_t band_ch [CH];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    mcc_channel #(
      .W      (W),
      .LO_TH  (LO_TH),
      .HI_TH  (HI_TH),
      .CNT_ON (CNT_ON)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .in       (in[k]),
      .clr      (clr[k]),
      .en       (en),
      .mode_sat (mode_sat),
      .out      (out[k*W +: W]),
      .band     (band_ch[k]),
      .evt      (evt[k]),
      .sat      (sat[k])
    );

    assign band[2*k +: 2] = band_ch[k];
  end

endmodule

// File: tb/tb_multi_cnt_classifier.sv
// Directed self-checking bench for multi_cnt_classifier (CH=4, W=8, LO_TH=4, HI_TH=16, CNT_ON=0).
module tb_multi_cnt_classifier;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;

  logic            clk;
  logic            reset;
  logic [CH-1:0]   din;
  logic [CH-1:0]   clr;
  logic            en;
  logic            mode_sat;
  logic [CH*W-1:0] out;
  logic [2*CH-1:0] band;
  logic [CH-1:0]   evt;
  logic [CH-1:0]   sat;

  int errors = 0;
  int checks = 0;

  multi_cnt_classifier #(
    .CH(CH), .W(W), .LO_TH(4), .HI_TH(16), .CNT_ON(1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .clr      (clr),
    .en       (en),
    .mode_sat (mode_sat),
    .out      (out),
    .band     (band),
    .evt      (evt),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = '1; clr = '0; en = 1'b1; mode_sat = 1'b0;
    tick(); tick();
    checks++;
    if ({out, band, evt, sat} !== '0) begin
      errors++;
      $display("FAIL reset_state: out=%h band=%b evt=%b sat=%b expected all zero", out, band, evt, sat);
    end
    reset = 1'b0;
  endtask

  task automatic test_count_to_mid();
    int exp_out [6] = '{0, 0, 0, 0, 16, 25};
    din = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out[7:0] !== 8'(exp_out[i])) begin
        errors++;
        $display("FAIL mid_out edge%0d: got %0d expected %0d", i + 1, out[7:0], exp_out[i]);
      end
      checks++;
      if (band[1:0] !== ((i >= 4) ? 2'b01 : 2'b00) || evt[0] !== (i == 4)) begin
        errors++;
        $display("FAIL mid_band edge%0d: band0=%b evt0=%b expected band0=%b evt0=%0d",
                 i + 1, band[1:0], evt[0], (i >= 4) ? 2'b01 : 2'b00, (i == 4));
      end
      checks++;
      if (out[31:8] !== '0 || evt[3:1] !== '0) begin
        errors++;
        $display("FAIL mid_idle edge%0d: out[31:8]=%h evt[3:1]=%b expected 0", i + 1, out[31:8], evt[3:1]);
      end
    end
  endtask

  task automatic test_count_to_high();
    int nevt = 0;
    for (int e = 7; e <= 18; e++) begin
      tick();
      if (evt[0]) nevt++;
      if (e == 10) begin
        checks++;
        if (out[7:0] !== 8'd81) begin
          errors++;
          $display("FAIL high_sq9: got %0d expected 81", out[7:0]);
        end
      end
      if (e == 17) begin
        checks++;
        if (out[7:0] !== 8'd0 || band[1:0] !== 2'b01) begin
          errors++;
          $display("FAIL high_sq16: out0=%0d band0=%b expected 0 01", out[7:0], band[1:0]);
        end
      end
      if (e == 18) begin
        checks++;
        if (out[7:0] !== 8'd8 || band[1:0] !== 2'b10 || evt[0] !== 1'b1) begin
          errors++;
          $display("FAIL high_enter: out0=%0d band0=%b evt0=%b expected 8 10 1", out[7:0], band[1:0], evt[0]);
        end
      end
    end
    checks++;
    if (nevt != 1) begin
      errors++;
      $display("FAIL high_evt_count: got %0d expected 1", nevt);
    end
  endtask

  task automatic test_wrap();
    clr = 4'b0001; din = 4'b1110;
    tick();
    checks++;
    if (out[7:0] !== 8'd0 || band[1:0] !== 2'b00 || evt[0] !== 1'b0 || sat[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_from_high: out0=%0d band0=%b evt0=%b sat0=%b expected 0 00 0 0",
               out[7:0], band[1:0], evt[0], sat[0]);
    end
    clr = '0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (n == 255 || n == 256) begin
        checks++;
        if (out[7:0] !== 8'd127 || band[1:0] !== 2'b10) begin
          errors++;
          $display("FAIL wrap_top edge%0d: out0=%0d band0=%b expected 127 10", n, out[7:0], band[1:0]);
        end
      end
    end
    din = 4'b1111;
    tick();
    checks++;
    if (out[7:0] !== 8'd0 || band[1:0] !== 2'b00 || evt[0] !== 1'b1 || sat[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_low: out0=%0d band0=%b evt0=%b sat0=%b expected 0 00 1 0",
               out[7:0], band[1:0], evt[0], sat[0]);
    end
  endtask

  task automatic test_saturate();
    mode_sat = 1'b1; din = 4'b1110;
    for (int n = 0; n < 300; n++) tick();
    checks++;
    if (sat !== 4'b0001 || out[7:0] !== 8'd127 || band[1:0] !== 2'b10 || evt !== '0) begin
      errors++;
      $display("FAIL sat_hold: sat=%b out0=%0d band0=%b evt=%b expected 0001 127 10 0000",
               sat, out[7:0], band[1:0], evt);
    end
    mode_sat = 1'b0; din = 4'b1111;
    tick();
    checks++;
    if (sat[0] !== 1'b1 || out[7:0] !== 8'd127) begin
      errors++;
      $display("FAIL sat_sticky: sat0=%b out0=%0d expected 1 127", sat[0], out[7:0]);
    end
    clr = 4'b0001; din = 4'b1110;
    tick();
    checks++;
    if (sat[0] !== 1'b0 || out[7:0] !== 8'd0 || band[1:0] !== 2'b00 || evt[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: sat0=%b out0=%0d band0=%b evt0=%b expected 0 0 00 0",
               sat[0], out[7:0], band[1:0], evt[0]);
    end
    clr = '0;
  endtask

  task automatic test_enable_hold();
    din = 4'b1010;
    for (int n = 0; n < 9; n++) tick();
    din = 4'b1011;
    for (int n = 0; n < 11; n++) tick();
    en = 1'b0; din = '0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (out !== {8'd0, 8'd10, 8'd0, 8'd81} || band !== 8'b00_10_00_01 || evt !== '0) begin
        errors++;
        $display("FAIL en_hold edge%0d: out=%h band=%b evt=%b expected 000a0051 00100001 0000",
                 n + 1, out, band, evt);
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; din = 4'b1111;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out, band, evt, sat} !== '0) begin
      errors++;
      $display("FAIL async_reset_mid: out=%h band=%b evt=%b sat=%b expected all zero", out, band, evt, sat);
    end
    din = 4'b1110;
    tick();
    checks++;
    if ({out, band, evt, sat} !== '0) begin
      errors++;
      $display("FAIL async_reset_held: out=%h band=%b evt=%b sat=%b expected all zero", out, band, evt, sat);
    end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (out[7:0] !== ((i == 5) ? 8'd16 : 8'd0) || band[1:0] !== ((i == 5) ? 2'b01 : 2'b00) ||
          evt[0] !== (i == 5)) begin
        errors++;
        $display("FAIL restart edge%0d: out0=%0d band0=%b evt0=%b expected %0d %b %0d",
                 i, out[7:0], band[1:0], evt[0], (i == 5) ? 16 : 0, (i == 5) ? 2'b01 : 2'b00, (i == 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_to_mid();
    test_count_to_high();
    test_wrap();
    test_saturate();
    test_enable_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
